scope_sample_writer: RTL and testbench

SCOPE_SAMPLE_WRITER -- requirements
Module: scope_sample_writer

---
 rtl/scope_sample_writer_if.sv | 23 ++
 rtl/scope_sample_writer.sv | 154 +++++++++++++++
 tb/tb_scope_sample_writer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scope_sample_writer_if.sv
// RAM write port driven by the scope sample writer.
interface scope_sample_writer_if #(
  parameter int unsigned AW = 16
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write;
  logic [7:0]    writedata;

  modport master (
    output address,
    output chipselect,
    output write,
    output writedata
  );

  modport slave (
    input address,
    input chipselect,
    input write,
    input writedata
  );
endinterface

// File: rtl/scope_sample_writer.sv
// Triggered oscilloscope capture: writes pre-trigger and post-trigger ADC
// samples into a circular sample RAM and reports the trigger sample address.
module scope_sample_writer #(
  parameter int unsigned DEPTH = 40096,
  parameter int unsigned AW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sample_valid,
  input  logic [7:0]             sample,
  input  logic [7:0]             trig_level,
  input  logic                   trig_slope,
  input  logic [AW-1:0]          pre_count,
  scope_sample_writer_if.master  ram,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          trig_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] cnt;
  logic [AW-1:0] pre_eff;
  logic [AW-1:0] post_len;
  logic [7:0]    prev_sample;
  logic          have_prev;

  logic          capturing_c;
  logic          accept_c;
  logic          trig_hit_c;
  logic [AW-1:0] wr_ptr_inc_c;
  logic [AW-1:0] cnt_inc_c;
  logic [AW-1:0] pre_clamp_c;

  // Sample acceptance and edge-crossing trigger against the last accepted sample
  always_comb begin
    capturing_c  = (state == PRE) || (state == ARMED) || (state == POST);
    accept_c     = sample_valid && !abort && capturing_c;
    trig_hit_c   = 1'b0;
    if (have_prev) begin
      if (trig_slope)
        trig_hit_c = (prev_sample < trig_level) && (sample >= trig_level);
      else
        trig_hit_c = (prev_sample > trig_level) && (sample <= trig_level);
    end
    wr_ptr_inc_c = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
    cnt_inc_c    = cnt + AW'(1);
    pre_clamp_c  = (32'(pre_count) > (DEPTH - 1)) ? LAST_ADDR : pre_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      cnt            <= '0;
      pre_eff        <= '0;
      post_len       <= '0;
      prev_sample    <= '0;
      have_prev      <= 1'b0;
      ram.address    <= '0;
      ram.chipselect <= 1'b0;
      ram.write      <= 1'b0;
      ram.writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      trig_addr      <= '0;
    end else begin
      ram.write      <= 1'b0;
      ram.chipselect <= 1'b0;

      // Every accepted sample is written one cycle later at the current pointer
      if (accept_c) begin
        ram.write      <= 1'b1;
        ram.chipselect <= 1'b1;
        ram.address    <= wr_ptr;
        ram.writedata  <= sample;
        wr_ptr         <= wr_ptr_inc_c;
        prev_sample    <= sample;
        have_prev      <= 1'b1;
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              wr_ptr    <= '0;
              cnt       <= '0;
              have_prev <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              pre_eff   <= pre_clamp_c;
              post_len  <= LAST_ADDR - pre_clamp_c;
              state     <= (pre_clamp_c == '0) ? ARMED : PRE;
            end
          end
          PRE: begin
            if (sample_valid) begin
              cnt <= cnt_inc_c;
              if (cnt_inc_c == pre_eff) begin
                cnt   <= '0;
                state <= ARMED;
              end
            end
          end
          ARMED: begin
            if (sample_valid && trig_hit_c) begin
              trig_addr <= wr_ptr;
              cnt       <= '0;
              // A full pre-trigger window leaves no room for post samples
              if (post_len == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (sample_valid) begin
              cnt <= cnt_inc_c;
              if (cnt_inc_c == post_len) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_sample_writer.sv
// Randomized bench for scope_sample_writer against a capture-level model.
module tb_scope_sample_writer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          sample_valid;
  logic [7:0]    sample;
  logic [7:0]    trig_level;
  logic          trig_slope;
  logic [AW-1:0] pre_count;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;

  always #5 clk = ~clk;

  scope_sample_writer_if #(.AW(AW)) ram ();

  scope_sample_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .pre_count    (pre_count),
    .ram          (ram.master),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr)
  );

  // Sample RAM attached to the write port
  logic [7:0] shadow [DEPTH];
  always @(posedge clk) begin
    if (ram.write) shadow[int'(ram.address) % DEPTH] <= ram.writedata;
  end

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] stim      [256];
  logic [7:0] model_mem [DEPTH];
  logic [7:0] snap      [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] s, input bit st, input bit ab);
    sample_valid = v;
    sample       = s;
    start        = st;
    abort        = ab;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
  endtask

  // Stream mostly on the non-triggering side, with a guaranteed crossing at 200/201
  task automatic fill_random(input bit slope, input logic [7:0] lvl);
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(7) == 0)
        stim[i] = 8'($urandom);
      else if (slope)
        stim[i] = 8'($urandom_range(int'(lvl) - 1, 0));
      else
        stim[i] = 8'($urandom_range(255, int'(lvl) + 1));
    end
    stim[200] = slope ? lvl - 8'd1 : lvl + 8'd1;
    stim[201] = lvl;
  endtask

  // One full capture: model derives trigger index and total length from the stream
  task automatic run_capture(input int pre, input bit slope, input logic [7:0] lvl,
                             input int navail, input int gap_pct, input bit poke_start,
                             output int t_out);
    int  pre_eff, t, total, ndrive, k, cyc;
    bit  v, st;
    pre_eff = (pre > int'(DEPTH) - 1) ? int'(DEPTH) - 1 : pre;
    t = -1;
    for (int i = (pre_eff > 1 ? pre_eff : 1); i < navail && t < 0; i++) begin
      if (slope ? (stim[i-1] < lvl && stim[i] >= lvl) : (stim[i-1] > lvl && stim[i] <= lvl))
        t = i;
    end
    total  = (t < 0) ? navail + 1000 : t + int'(DEPTH) - pre_eff;
    for (int i = 0; i < total && i < navail; i++) model_mem[i % DEPTH] = stim[i];
    ndrive = (total + 4 < navail) ? total + 4 : navail;

    trig_level = lvl;
    trig_slope = slope;
    pre_count  = AW'(pre);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_write", 32'(ram.write), 32'd0);
    pre_count = AW'($urandom);

    k   = 0;
    cyc = 0;
    while (k < ndrive && cyc < 4000) begin
      v  = ($urandom_range(99) >= gap_pct);
      st = poke_start && (k < total) && ($urandom_range(15) == 0);
      step(v, v ? stim[k] : 8'($urandom), st, 1'b0);
      if (v) begin
        check("write", 32'(ram.write), 32'(k < total));
        if (k < total) begin
          check("addr", 32'(ram.address), 32'(k % DEPTH));
          check("data", 32'(ram.writedata), 32'(stim[k]));
          check("cs", 32'(ram.chipselect), 32'd1);
        end
        k++;
      end else begin
        check("gap_write", 32'(ram.write), 32'd0);
      end
      check("busy", 32'(busy), 32'(k < total));
      check("done", 32'(done), 32'(k >= total));
      cyc++;
    end
    if (cyc >= 4000) check("timeout", 32'd0, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("done_hold", 32'(done), 32'(k >= total));
    if (t >= 0) check("trig_addr", 32'(trig_addr), 32'(t % DEPTH));
    if (t >= 0 && k >= total) begin
      for (int i = 0; i < int'(DEPTH); i++) check("ram", 32'(shadow[i]), 32'(model_mem[i]));
    end
    t_out = t;
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    start        = 1'b1;
    abort        = 1'b0;
    sample_valid = 1'b1;
    sample       = 8'h5A;
    trig_level   = 8'h80;
    trig_slope   = 1'b1;
    pre_count    = AW'(4);
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(ram.address), 32'd0);
    check("rst_cs", 32'(ram.chipselect), 32'd0);
    check("rst_write", 32'(ram.write), 32'd0);
    check("rst_wdata", 32'(ram.writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig", 32'(trig_addr), 32'd0);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Ramp through the rising threshold
    for (int i = 0; i < 256; i++) stim[i] = 8'(i * 16);
    run_capture(4, 1'b1, 8'h80, 256, 0, 1'b0, t);
    check("ramp_trig", 32'(trig_addr), 32'd8);

    // Long ARMED phase wraps the write pointer
    for (int i = 0; i < 256; i++) stim[i] = (i < 40) ? 8'h10 : ((i == 40) ? 8'h90 : 8'h20);
    run_capture(4, 1'b1, 8'h80, 256, 30, 1'b0, t);
    check("wrap_trig", 32'(trig_addr), 32'd8);

    // Falling slope: first sample and equal-to-level predecessor never trigger
    for (int i = 0; i < 256; i++) stim[i] = 8'h20;
    stim[0] = 8'h40; stim[1] = 8'h30; stim[2] = 8'h50; stim[3] = 8'h40;
    run_capture(0, 1'b0, 8'h40, 256, 20, 1'b0, t);
    check("fall_trig", 32'(trig_addr), 32'd3);

    // Zero pre-trigger: second sample triggers
    fill_random(1'b1, 8'h80);
    stim[0] = 8'h00; stim[1] = 8'hFF;
    run_capture(0, 1'b1, 8'h80, 256, 0, 1'b0, t);
    check("pre0_trig", 32'(trig_addr), 32'd1);

    // Oversized pre-trigger count clamps to DEPTH-1
    fill_random(1'b1, 8'h60);
    run_capture(200, 1'b1, 8'h60, 256, 25, 1'b0, t);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] lvl;
      bit         slope;
      lvl   = 8'($urandom_range(254, 1));
      slope = 1'($urandom_range(1));
      fill_random(slope, lvl);
      run_capture(int'($urandom_range(20)), slope, lvl, 256, int'($urandom_range(60)), 1'b1, t);
    end

    // Abort in POST with a simultaneous sample; start mid-capture is ignored
    for (int i = 0; i < 256; i++) stim[i] = 8'(i * 16);
    trig_level = 8'h80;
    trig_slope = 1'b1;
    pre_count  = AW'(4);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, stim[i], (i == 2), 1'b0);
    check("post_busy", 32'(busy), 32'd1);
    check("post_trig", 32'(trig_addr), 32'd8);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    check("abort_write", 32'(ram.write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_trig", 32'(trig_addr), 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h77, 1'b0, 1'b0);
      check("idle_write", 32'(ram.write), 32'd0);
    end
    step(1'b1, 8'h33, 1'b1, 1'b1);
    check("abort_over_start", 32'(busy), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("abort_over_start_w", 32'(ram.write), 32'd0);

    // Reset while ARMED discards the capture and freezes RAM contents
    trig_level = 8'hF0;
    pre_count  = AW'(2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10, 1'b0, 1'b0);
    check("armed_busy", 32'(busy), 32'd1);
    reset        = 1'b1;
    start        = 1'b1;
    sample_valid = 1'b1;
    sample       = 8'hC3;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) snap[i] = shadow[i];
    check("mid_rst_addr", 32'(ram.address), 32'd0);
    check("mid_rst_cs", 32'(ram.chipselect), 32'd0);
    check("mid_rst_write", 32'(ram.write), 32'd0);
    check("mid_rst_wdata", 32'(ram.writedata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_trig", 32'(trig_addr), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hE5, 1'b0, 1'b0);
      check("post_rst_write", 32'(ram.write), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < int'(DEPTH); i++) check("ram_frozen", 32'(shadow[i]), 32'(snap[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
